// File: rtl/cru_pkg.sv
// Shared types and helpers for the per-set cache replacement unit.
package cru_pkg;

  typedef enum logic {CRU_RR, CRU_PLRU} cru_policy_e;

  // Widest valid mask first_zero can scan; callers pad unused upper bits with ones.
  localparam int CRU_MAX_WAYS = 64;

  function automatic int first_zero(input logic [CRU_MAX_WAYS-1:0] mask);
    int idx;
    idx = 0;
    for (int i = CRU_MAX_WAYS - 1; i >= 0; i--) begin
      if (!mask[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/policy_cru_plru_tree.sv
// Tree pseudo-LRU walk for one set: victim lookup and touch update, purely combinational.
module plru_tree #(
  parameter  int NUM_WAYS       = 4,
  localparam int WAY_INDEX_SIZE = $clog2(NUM_WAYS),
  localparam int TREE_BITS      = NUM_WAYS - 1
) (
  input  logic [TREE_BITS-1:0]      tree,
  input  logic [WAY_INDEX_SIZE-1:0] touch_way,
  output logic [WAY_INDEX_SIZE-1:0] victim,
  output logic [TREE_BITS-1:0]      tree_next
);

  // Victim and touch are separate processes so touch_way may depend on victim.
  always_comb begin : victim_walk
    int   node;
    logic dir;
    victim = '0;
    node   = 0;
    for (int lvl = 0; lvl < WAY_INDEX_SIZE; lvl++) begin
      dir = 1'b0;
      for (int n = 0; n < TREE_BITS; n++) begin
        if (n == node) dir = tree[n];
      end
      victim[WAY_INDEX_SIZE-1-lvl] = dir;
      node = 2 * node + 1 + int'(dir);
    end
  end

  always_comb begin : touch_walk
    int   node;
    logic dir;
    tree_next = tree;
    node      = 0;
    for (int lvl = 0; lvl < WAY_INDEX_SIZE; lvl++) begin
      dir = touch_way[WAY_INDEX_SIZE-1-lvl];
      for (int n = 0; n < TREE_BITS; n++) begin
        if (n == node) tree_next[n] = ~dir;
      end
      node = 2 * node + 1 + int'(dir);
    end
  end

endmodule

// File: rtl/policy_cru.sv
// Per-set replacement unit: invalid-way preference over a round-robin or tree-PLRU victim.
module policy_cru
  import cru_pkg::*;
#(
  parameter  int          NUM_SETS       = 16,
  parameter  int          NUM_WAYS       = 4,
  parameter  cru_policy_e POLICY         = CRU_RR,
  localparam int          SET_INDEX_SIZE = $clog2(NUM_SETS),
  localparam int          WAY_INDEX_SIZE = $clog2(NUM_WAYS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [SET_INDEX_SIZE-1:0] set_index,
  input  logic [NUM_WAYS-1:0]       valid_mask,
  input  logic                      hit,
  input  logic [WAY_INDEX_SIZE-1:0] hit_way,
  input  logic                      replace,
  output logic [WAY_INDEX_SIZE-1:0] preferred,
  output logic                      preferred_invalid
);

  if ((NUM_WAYS < 2) || ((NUM_WAYS & (NUM_WAYS - 1)) != 0) || (NUM_WAYS >= CRU_MAX_WAYS)) begin : g_bad_ways
    $error("policy_cru: NUM_WAYS must be a power of 2 between 2 and 32");
  end
  if ((NUM_SETS < 2) || ((NUM_SETS & (NUM_SETS - 1)) != 0)) begin : g_bad_sets
    $error("policy_cru: NUM_SETS must be a power of 2, at least 2");
  end

  logic [WAY_INDEX_SIZE-1:0] policy_victim;
  logic [WAY_INDEX_SIZE-1:0] first_invalid;
  logic                      all_valid;

  assign all_valid         = &valid_mask;
  assign first_invalid     = WAY_INDEX_SIZE'(first_zero({{(CRU_MAX_WAYS - NUM_WAYS){1'b1}}, valid_mask}));
  assign preferred_invalid = ~all_valid;
  assign preferred         = all_valid ? policy_victim : first_invalid;

  if (POLICY == CRU_RR) begin : g_rr
    logic [WAY_INDEX_SIZE-1:0] rr_ptr [NUM_SETS];

    assign policy_victim = rr_ptr[set_index];

    // Filling an invalid way leaves the rotation where it was.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        for (int s = 0; s < NUM_SETS; s++) rr_ptr[s] <= '0;
      end else if (replace && !preferred_invalid) begin
        rr_ptr[set_index] <= rr_ptr[set_index] + 1'b1;
      end
    end
  end else begin : g_plru
    localparam int TREE_BITS = NUM_WAYS - 1;

    logic [TREE_BITS-1:0]      plru_bits [NUM_SETS];
    logic [TREE_BITS-1:0]      tree_next;
    logic [WAY_INDEX_SIZE-1:0] touch_way;

    // A fill outranks a concurrent hit on the same cycle.
    assign touch_way = replace ? preferred : hit_way;

    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_tree (
      .tree      (plru_bits[set_index]),
      .touch_way (touch_way),
      .victim    (policy_victim),
      .tree_next (tree_next)
    );

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        for (int s = 0; s < NUM_SETS; s++) plru_bits[s] <= '0;
      end else if (replace || hit) begin
        plru_bits[set_index] <= tree_next;
      end
    end
  end

  a_hit_way_range: assert property (@(posedge clk) disable iff (rst) hit |-> (int'(hit_way) < NUM_WAYS));

endmodule
